// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for the UART TX arbiter.
// The arbiter connects to the master modport and the requesters and UART to the slave modport.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into a single UART transmitter.
// A busy-rise watchdog returns the arbiter to IDLE if the transmitter never acknowledges a start.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int BUSY_TIMEOUT = 16,
  localparam int GW           = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus,
  output logic [GW-1:0]     grant_id,
  output logic              active,
  output logic              timeout_err,
  output logic [15:0]       byte_count
);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] cnt;
  logic [GW-1:0] win;
  logic [GW-1:0] idx;
  logic          found;

  // Search starts one past the last grantee so every requester gets a turn.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign active = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.req_ready <= '0;
      grant_id      <= '0;
      last_grant    <= GW'(NUM_REQ - 1);
      cnt           <= '0;
      timeout_err   <= 1'b0;
      byte_count    <= 16'h0000;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !bus.tx_busy) begin
            state         <= START;
            bus.tx_start  <= 1'b1;
            bus.tx_data   <= bus.req_data[win];
            bus.req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            grant_id      <= win;
            last_grant    <= win;
          end
        end
        START: begin
          bus.tx_start  <= 1'b0;
          bus.req_ready <= '0;
          cnt           <= '0;
          state         <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // An acknowledge on the last allowed cycle still wins over the timeout.
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state      <= IDLE;
            byte_count <= byte_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
